// File: rtl/z80bus_arb.sv
// Round-robin two-requester Z80 bus master: one mem/io cycle per grant.
// Optional Z80BUS_ARB_WAIT_EN adds a wait_n input that stretches ACTIVE.
module z80bus_arb #(
   parameter int SETUP = 1,
   parameter int PULSE = 2,
   parameter int HOLD  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic [1:0]  cmd0,
   input  logic [15:0] addr0,
   input  logic [7:0]  wdata0,
   output logic        ack0,
   input  logic        req1,
   input  logic [1:0]  cmd1,
   input  logic [15:0] addr1,
   input  logic [7:0]  wdata1,
   output logic        ack1,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic        mreq_n,
   output logic        iorq_n,
   output logic        rd_n,
   output logic        wr_n,
   output logic [15:0] a,
   output logic [7:0]  d_out,
   output logic        d_oe,
`ifdef Z80BUS_ARB_WAIT_EN
   input  logic        wait_n,
`endif
   input  logic [7:0]  d_in
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACTIVE,
      S_HOLD
   } state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [1:0]  cmd_q;
   logic        gnt;
   logic        last_grant;

   logic        v0;
   logic        v1;
   logic        any;
   logic        pick;
   logic [1:0]  cmd_sel;
   logic [15:0] addr_sel;
   logic [7:0]  wdata_sel;
   logic        wait_ok;
   logic        is_io;
   logic        is_wr;

`ifdef Z80BUS_ARB_WAIT_EN
   assign wait_ok = wait_n;
`else
   assign wait_ok = 1'b1;
`endif

   assign is_io = cmd_q[1];
   assign is_wr = cmd_q[0];

   // A requester still seeing its ack this clock is not a new request.
   always_comb begin
      v0        = req0 & ~ack0;
      v1        = req1 & ~ack1;
      any       = v0 | v1;
      pick      = (v0 & v1) ? ~last_grant : v1;
      cmd_sel   = pick ? cmd1 : cmd0;
      addr_sel  = pick ? addr1 : addr0;
      wdata_sel = pick ? wdata1 : wdata0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         cmd_q      <= '0;
         gnt        <= 1'b0;
         last_grant <= 1'b1;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         busy       <= 1'b0;
         rdata      <= '0;
         mreq_n     <= 1'b1;
         iorq_n     <= 1'b1;
         rd_n       <= 1'b1;
         wr_n       <= 1'b1;
         a          <= '0;
         d_out      <= '0;
         d_oe       <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (any) begin
                  gnt        <= pick;
                  last_grant <= pick;
                  cmd_q      <= cmd_sel;
                  a          <= addr_sel;
                  d_out      <= wdata_sel;
                  d_oe       <= cmd_sel[0];
                  busy       <= 1'b1;
                  cnt        <= '0;
                  state      <= S_SETUP;
               end
            end
            // The grant clock itself counts as address setup too.
            S_SETUP: begin
               if (cnt == 16'(SETUP)) begin
                  cnt    <= '0;
                  mreq_n <= is_io;
                  iorq_n <= ~is_io;
                  rd_n   <= is_wr;
                  wr_n   <= ~(is_io & is_wr);
                  state  <= S_ACTIVE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_ACTIVE: begin
               if (cnt == 16'(PULSE - 1) && wait_ok) begin
                  cnt    <= '0;
                  mreq_n <= 1'b1;
                  iorq_n <= 1'b1;
                  rd_n   <= 1'b1;
                  wr_n   <= 1'b1;
                  if (!is_wr)
                     rdata <= d_in;
                  state  <= S_HOLD;
               end else begin
                  if (cnt != 16'(PULSE - 1))
                     cnt <= cnt + 16'd1;
                  if (is_wr)
                     wr_n <= 1'b0;
               end
            end
            S_HOLD: begin
               if (cnt == 16'(HOLD - 1)) begin
                  cnt   <= '0;
                  d_oe  <= 1'b0;
                  busy  <= 1'b0;
                  ack0  <= ~gnt;
                  ack1  <= gnt;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_z80bus_arb.sv
// Randomized bench for z80bus_arb against a timeline reference model.
// Define Z80BUS_ARB_WAIT_EN to also exercise the wait_n stretch.
module tb_z80bus_arb;

   localparam int S   = 1;
   localparam int P   = 2;
   localparam int H   = 1;
   localparam int LAT = 1 + S + P + H;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [1:0]  cmd0 = '0, cmd1 = '0;
   logic [15:0] addr0 = '0, addr1 = '0;
   logic [7:0]  wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1;
   logic [7:0]  rdata;
   logic        busy;
   logic        mreq_n, iorq_n, rd_n, wr_n;
   logic [15:0] a;
   logic [7:0]  d_out;
   logic        d_oe;
   logic [7:0]  d_in = '0;
`ifdef Z80BUS_ARB_WAIT_EN
   logic        wait_n = 1'b1;
`endif

   z80bus_arb dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .cmd0(cmd0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .cmd1(cmd1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .busy(busy),
      .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
      .a(a), .d_out(d_out), .d_oe(d_oe),
`ifdef Z80BUS_ARB_WAIT_EN
      .wait_n(wait_n),
`endif
      .d_in(d_in)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Model: one grant record; every output is a function of edge offset k.
   int          E = 0;
   int          g = 0;
   bit          gv = 0;
   bit          r = 0;
   bit          ml = 1;
   bit          in_rst = 1;
   logic [1:0]  mc = '0;
   logic [15:0] ma = '0;
   logic [7:0]  mw = '0;
   logic [7:0]  mr = '0;
   logic [7:0]  x_ctl = 8'b0001_1110;

   task automatic model_reset();
      gv = 0; ml = 1; mc = '0; ma = '0; mw = '0; mr = '0;
      x_ctl = 8'b0001_1110;
   endtask

   task automatic model_edge();
      int k;
      bit c0, c1, v0, v1, p, sw, act;
      c0 = gv && (E == g + LAT + 1) && !r;
      c1 = gv && (E == g + LAT + 1) && r;
      if (!in_rst) begin
         if (!gv || E - g > LAT) begin
            v0 = req0 && !c0;
            v1 = req1 && !c1;
            if (v0 || v1) begin
               p  = (v0 && v1) ? !ml : v1;
               gv = 1; g = E; r = p; ml = p;
               mc = p ? cmd1 : cmd0;
               ma = p ? addr1 : addr0;
               mw = p ? wdata1 : wdata0;
            end
         end else if (E - g == 1 + S + P && !mc[0]) begin
            mr = d_in;
         end
      end
      k   = E - g;
      act = gv && k < LAT;
      sw  = gv && k >= 1 + S && k < 1 + S + P;
      x_ctl[7] = gv && k == LAT && !r;
      x_ctl[6] = gv && k == LAT && r;
      x_ctl[5] = act;
      x_ctl[4] = !(sw && !mc[1]);
      x_ctl[3] = !(sw && mc[1]);
      x_ctl[2] = !(sw && !mc[0]);
      x_ctl[1] = !(sw && mc[0] && (mc[1] || k >= 2 + S));
      x_ctl[0] = act && mc[0];
      E++;
   endtask

   task automatic step();
      model_edge();
      @(negedge clk);
      chk("ctl", 32'({ack0, ack1, busy, mreq_n, iorq_n, rd_n, wr_n, d_oe}),
          32'(x_ctl));
      chk("a", 32'(a), 32'(ma));
      chk("d_out", 32'(d_out), 32'(mw));
      chk("rdata", 32'(rdata), 32'(mr));
   endtask

   task automatic run_until_ack(input bit which, input int budget,
                                output int n);
      n = 0;
      forever begin
         step();
         n++;
         if ((!which && ack0) || (which && ack1)) break;
         if (n >= budget) begin
            chk("ack_timeout", 32'(n), 32'(0));
            break;
         end
      end
   endtask

   task automatic agent(input bit ak, input bit mine, inout logic rq,
                        inout logic [1:0] c, inout logic [15:0] ad,
                        inout logic [7:0] wd);
      if (ak) begin
         rq = 1'($urandom_range(0, 1));
         c = 2'($urandom); ad = 16'($urandom); wd = 8'($urandom);
      end else if (!rq) begin
         if ($urandom_range(0, 3) == 0) begin
            rq = 1'b1;
            c = 2'($urandom); ad = 16'($urandom); wd = 8'($urandom);
         end
      end else begin
         if ($urandom_range(0, 2) == 0) begin
            ad = 16'($urandom); wd = 8'($urandom); c = 2'($urandom);
         end
         if (mine && $urandom_range(0, 15) == 0) rq = 1'b0;
      end
   endtask

   initial begin
      int n;
      int lowm, lowr;
      bit got;
      req0 = 1'b1; cmd0 = 2'b01; addr0 = 16'h1234; wdata0 = 8'hA5;
      step();
      step();
      rst_n = 1'b1;
      in_rst = 0;
      step();
      chk("grant_busy", 32'(busy), 32'(1));
      run_until_ack(1'b0, 20, n);
      chk("lat", 32'(n), 32'(LAT));
      req0 = 1'b0;
      req1 = 1'b1; cmd1 = 2'b10; addr1 = 16'h00FE; d_in = 8'h3C;
      run_until_ack(1'b1, 20, n);
      chk("rd3c", 32'(rdata), 32'(8'h3C));
      req1 = 1'b0;
      step();

      for (int i = 0; i < 800; i++) begin
         d_in = 8'($urandom);
         agent(x_ctl[7], x_ctl[5] && !r, req0, cmd0, addr0, wdata0);
         agent(x_ctl[6], x_ctl[5] && r, req1, cmd1, addr1, wdata1);
         step();
      end

      req0 = 1'b0; req1 = 1'b0;
      n = 0;
      while ((x_ctl[5] || x_ctl[7] || x_ctl[6]) && n < 20) begin
         step();
         n++;
      end
      step();
      req0 = 1'b1; cmd0 = 2'b11; addr0 = 16'hBEEF; wdata0 = 8'h77;
      n = 0;
      do begin
         step();
         n++;
      end while (x_ctl[3] && n < 12);
      chk("iowr_active", 32'(iorq_n), 32'(0));
      rst_n = 1'b0;
      #1;
      chk("rst_strobe", 32'({mreq_n, iorq_n, rd_n, wr_n}), 32'(4'hF));
      chk("rst_doe", 32'(d_oe), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      model_reset();
      in_rst = 1;
      req0 = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      in_rst = 0;
      repeat (8) step();

`ifdef Z80BUS_ARB_WAIT_EN
      req0 = 1'b1; cmd0 = 2'b00; addr0 = 16'h4000; d_in = 8'h00;
      lowm = 0; lowr = 0; got = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!mreq_n) lowm++;
         if (!rd_n) lowr++;
         if (!mreq_n && lowm == 2) begin wait_n = 1'b0; d_in = 8'h5A; end
         if (!mreq_n && lowm == 5) begin wait_n = 1'b1; d_in = 8'hC3; end
         if (ack0) begin
            got = 1;
            chk("wait_rdata", 32'(rdata), 32'(8'hC3));
            break;
         end
      end
      req0 = 1'b0;
      chk("wait_ack", 32'(got), 32'(1));
      chk("wait_mreq", 32'(lowm), 32'(5));
      chk("wait_rd", 32'(lowr), 32'(5));
`else
      lowm = 0; lowr = 0; got = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/z80bus_arb.md
Name: z80bus_arb

Overview:
Synthesizable Z80-style bus master that shares one external Z80 bus (mreq_n/iorq_n/rd_n/wr_n, 16-bit address, 8-bit data) between two requesters, such as the USB-side host logic and an on-chip test sequencer. It arbitrates round-robin and runs one complete memory or I/O cycle per grant, with clock-counted setup, strobe and hold phases. It reports completion with a one-clock ack and returns read data.

Parameters:
SETUP, 1, clocks with address valid and all strobes high before strobes assert (>=1)
PULSE, 2, clocks that mreq_n/iorq_n stay low (>=2)
HOLD, 1, clocks after strobes release with address and write data still driven (>=1)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 request, held until ack0
cmd0  in  2  00 memrd, 01 memwr, 10 iord, 11 iowr
addr0  in  16  requester 0 address
wdata0  in  8  requester 0 write data
ack0  out  1  one-clock completion pulse for requester 0
req1, cmd1, addr1, wdata1, ack1  -  same as above, for requester 1
rdata  out  8  read data of the last completed read, valid from the ack clock
busy  out  1  high from the grant edge until the ack clock
mreq_n, iorq_n, rd_n, wr_n  out  1 each  bus strobes, active low
a  out  16  bus address
d_out  out  8  bus write data
d_oe  out  1  write-data output enable, for the top-level tristate
d_in  in  8  bus read data

Behaviour:
- Reset (asynchronous, active-low): all strobes 1, a=0, d_out=0, d_oe=0, rdata=0, ack0=ack1=0, busy=0, state IDLE, last_grant=1 so requester 0 wins first. Reset mid-cycle: strobes go high immediately, the cycle is abandoned and no ack is issued.
- FSM states: IDLE -> SETUP -> ACTIVE -> HOLD -> IDLE.
- IDLE arbitration:
  - A requester whose ack is high in the current clock is ignored.
  - One valid request: grant it.
  - Both valid: grant the one not equal to last_grant, then update last_grant.
- Grant edge: latch cmd, addr and wdata internally. Set a=addr, d_out=wdata, d_oe=1 for memwr/iowr, busy=1. Go to SETUP.
- SETUP: lasts SETUP clocks, all strobes high.
- ACTIVE: lasts PULSE clocks.
  - mreq_n=0 for memrd/memwr; iorq_n=0 for iord/iowr.
  - rd_n=0 for reads, for all PULSE clocks.
  - iowr: wr_n=0 for all PULSE clocks.
  - memwr: wr_n=0 from the 2nd ACTIVE clock (lags mreq_n by one clock).
- Last ACTIVE edge: for reads, d_in is captured into rdata; all strobes return high; go to HOLD.
- HOLD: lasts HOLD clocks, a and d_out unchanged. On its last edge: d_oe=0, ack of the granted requester=1 for exactly one clock, busy=0, go to IDLE.
- Latency: grant edge to ack rising = 1+SETUP+PULSE+HOLD clocks (5 at defaults).
- Back-to-back: the earliest next grant is on the ack clock, to the other requester only. The same requester can be granted one clock later. Bus minimum idle between cycles is one clock with strobes high.
- Request dropped after grant: the cycle still completes and ack still pulses.
- Request inputs are only sampled on the grant edge; later changes to cmd/addr/wdata have no effect on the running cycle.
- rdata holds its value until the next read completes; writes do not alter it.

Optional Feature:
Macro Z80BUS_ARB_WAIT_EN.
- Defined: adds input wait_n (1 bit, active low, synchronous to clk). It is sampled in ACTIVE on every edge where the PULSE counter would expire. While wait_n=0, ACTIVE is extended one clock at a time with strobes held low, and rdata is captured on the first expiry edge with wait_n=1.
- Not defined: the port is absent and ACTIVE is exactly PULSE clocks.

Test Plan:
- Reset with req0=1 held: all strobes 1, a=0, d_oe=0. Release -> grant to requester 0 next edge, ack0 exactly 5 clocks after the grant edge.
- req0 memwr addr=16'h1234 wdata=8'hA5 -> mreq_n low 2 clocks, wr_n low only in the 2nd, d_oe=1 with d_out=8'hA5 from grant through HOLD, a=16'h1234 throughout.
- req1 iord addr=16'h00FE, d_in=8'h3C -> iorq_n=rd_n=0 for 2 clocks, mreq_n stays 1, rdata=8'h3C on the ack1 clock.
- req0 and req1 asserted together and held -> grants alternate 0,1,0,1. Each ack is followed by the other requester's grant on the same clock, and acks never overlap.
- rst_n pulsed low during ACTIVE of an iowr -> strobes high and d_oe=0 immediately, no ack, busy=0.
- With Z80BUS_ARB_WAIT_EN: memrd, wait_n low for 3 clocks at expiry -> mreq_n/rd_n low 5 clocks total, rdata captured after wait_n rises.
